// File: rtl/states_pkg.sv
// ============================================================================
// states_pkg: shared state encodings for the LSU, core and memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package states_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_t;

    typedef enum logic [2:0] {
        CH_IDLE           = 3'd0,
        CH_READ_WAITING   = 3'd1,
        CH_WRITE_WAITING  = 3'd2,
        CH_READ_RELAYING  = 3'd3,
        CH_WRITE_RELAYING = 3'd4
    } channel_state_t;

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter: fixed-priority arbiter mapping LSU loads/stores onto N channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import states_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    channel_state_t                          state_q [NUM_CHANNELS];
    channel_state_t                          state_d [NUM_CHANNELS];
    logic [IDX_BITS-1:0]                     owner_q [NUM_CHANNELS];
    logic [IDX_BITS-1:0]                     owner_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                claimed_q, claimed_d;
    logic [NUM_CHANNELS-1:0]                 mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]                crr_q, crr_d, cwr_q, cwr_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_q, crd_d;

    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [IDX_BITS-1:0]      pick;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        claimed_d = claimed_q;
        mrv_d     = mrv_q;
        mra_d     = mra_q;
        mwv_d     = mwv_q;
        mwa_d     = mwa_q;
        mwd_d     = mwd_q;
        crr_d     = crr_q;
        cwr_d     = cwr_q;
        crd_d     = crd_q;
        taken     = claimed_q;
        found     = 1'b0;
        pick      = '0;

        // Channels are visited in ascending order; 'taken' grows as each one claims.
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            pick  = '0;
            case (state_q[ch])
                CH_IDLE: begin
                    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
                        if (!taken[i] && (consumer_read_valid[i] || consumer_write_valid[i])) begin
                            found = 1'b1;
                            pick  = IDX_BITS'(i);
                        end
                    end
                    if (found) begin
                        taken[pick]     = 1'b1;
                        claimed_d[pick] = 1'b1;
                        owner_d[ch]     = pick;
                        if (consumer_read_valid[pick]) begin
                            mrv_d[ch]   = 1'b1;
                            mra_d[ch]   = consumer_read_address[pick];
                            state_d[ch] = CH_READ_WAITING;
                        end else begin
                            mwv_d[ch]   = 1'b1;
                            mwa_d[ch]   = consumer_write_address[pick];
                            mwd_d[ch]   = consumer_write_data[pick];
                            state_d[ch] = CH_WRITE_WAITING;
                        end
                    end
                end
                CH_READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mrv_d[ch]          = 1'b0;
                        crd_d[owner_q[ch]] = mem_read_data[ch];
                        crr_d[owner_q[ch]] = 1'b1;
                        state_d[ch]        = CH_READ_RELAYING;
                    end
                end
                CH_WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        mwv_d[ch]          = 1'b0;
                        cwr_d[owner_q[ch]] = 1'b1;
                        state_d[ch]        = CH_WRITE_RELAYING;
                    end
                end
                CH_READ_RELAYING: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        crr_d[owner_q[ch]]     = 1'b0;
                        claimed_d[owner_q[ch]] = 1'b0;
                        state_d[ch]            = CH_IDLE;
                    end
                end
                CH_WRITE_RELAYING: begin
                    if (!consumer_write_valid[owner_q[ch]]) begin
                        cwr_d[owner_q[ch]]     = 1'b0;
                        claimed_d[owner_q[ch]] = 1'b0;
                        state_d[ch]            = CH_IDLE;
                    end
                end
                default: state_d[ch] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= CH_IDLE;
                owner_q[ch] <= '0;
            end
            claimed_q <= '0;
            mrv_q     <= '0;
            mra_q     <= '0;
            mwv_q     <= '0;
            mwa_q     <= '0;
            mwd_q     <= '0;
            crr_q     <= '0;
            cwr_q     <= '0;
            crd_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            claimed_q <= claimed_d;
            mrv_q     <= mrv_d;
            mra_q     <= mra_d;
            mwv_q     <= mwv_d;
            mwa_q     <= mwa_d;
            mwd_q     <= mwd_d;
            crr_q     <= crr_d;
            cwr_q     <= cwr_d;
            crd_q     <= crd_d;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign consumer_write_ready = cwr_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// tb_data_mem_arbiter: cycle-by-cycle vector table plus a reset-mid-read sequence.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]      rv, wv, crr, cwr;
    logic [3:0][7:0] ra, wa, wd, crd;
    logic [1:0]      mrv, mrr, mwv, mwr;
    logic [1:0][7:0] mra, mrd, mwa, mwd;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_BITS    (8),
        .DATA_BITS    (8),
        .NUM_CONSUMERS(4),
        .NUM_CHANNELS (2)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (rv),
        .consumer_read_address (ra),
        .consumer_read_ready   (crr),
        .consumer_read_data    (crd),
        .consumer_write_valid  (wv),
        .consumer_write_address(wa),
        .consumer_write_data   (wd),
        .consumer_write_ready  (cwr),
        .mem_read_valid        (mrv),
        .mem_read_address      (mra),
        .mem_read_ready        (mrr),
        .mem_read_data         (mrd),
        .mem_write_valid       (mwv),
        .mem_write_address     (mwa),
        .mem_write_data        (mwd),
        .mem_write_ready       (mwr)
    );

    typedef struct {
        logic [3:0]  rv;
        logic [3:0]  wv;
        logic [1:0]  mrr;
        logic [1:0]  mwr;
        logic [15:0] mrd;
        logic [1:0]  e_mrv;
        logic [15:0] e_mra;
        logic [1:0]  e_mwv;
        logic [15:0] e_mwa;
        logic [15:0] e_mwd;
        logic [3:0]  e_crr;
        logic [3:0]  e_cwr;
        logic [31:0] e_crd;
    } vec_t;

    localparam int NROWS = 29;
    vec_t tbl [NROWS];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    // Addresses/data are only meaningful on channels whose valid is expected high.
    task automatic chk_ch(input string nm, input int row, input logic [1:0] vld,
                          input logic [15:0] act, input logic [15:0] exp);
        logic [15:0] m;
        m = {{8{vld[1]}}, {8{vld[0]}}};
        if (vld != 2'b00) chk(nm, row, 32'(act & m), 32'(exp & m));
    endtask

    task automatic run_row(input int k);
        rv  = tbl[k].rv;
        wv  = tbl[k].wv;
        mrr = tbl[k].mrr;
        mwr = tbl[k].mwr;
        mrd = tbl[k].mrd;
        @(posedge clk);
        #1;
        chk("mem_read_valid", k, 32'(mrv), 32'(tbl[k].e_mrv));
        chk_ch("mem_read_address", k, tbl[k].e_mrv, mra, tbl[k].e_mra);
        chk("mem_write_valid", k, 32'(mwv), 32'(tbl[k].e_mwv));
        chk_ch("mem_write_address", k, tbl[k].e_mwv, mwa, tbl[k].e_mwa);
        chk_ch("mem_write_data", k, tbl[k].e_mwv, mwd, tbl[k].e_mwd);
        chk("consumer_read_ready", k, 32'(crr), 32'(tbl[k].e_crr));
        chk("consumer_write_ready", k, 32'(cwr), 32'(tbl[k].e_cwr));
        chk("consumer_read_data", k, crd, tbl[k].e_crd);
    endtask

    initial begin
        reset = 1'b0;
        rv = '0; wv = '0; mrr = '0; mwr = '0; mrd = '0;
        ra = {8'h3F, 8'h1A, 8'h21, 8'h10};
        wa = {8'h66, 8'h55, 8'h44, 8'h03};
        wd = {8'hD8, 8'hC7, 8'hB6, 8'hA5};

        //            rv       wv       mrr    mwr    mrd       e_mrv  e_mra     e_mwv  e_mwa     e_mwd     e_crr    e_cwr    e_crd
        // single read: consumer 2, addr 0x1A, data 0x5C after 3 cycles
        tbl[0]  = '{4'b0100, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b01, 16'h001A, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h00000000};
        tbl[1]  = '{4'b0100, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b01, 16'h001A, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h00000000};
        tbl[2]  = '{4'b0100, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b01, 16'h001A, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h00000000};
        tbl[3]  = '{4'b0100, 4'b0000, 2'b01, 2'b00, 16'h005C, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0100, 4'b0000, 32'h005C0000};
        tbl[4]  = '{4'b0100, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0100, 4'b0000, 32'h005C0000};
        tbl[5]  = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C0000};
        tbl[6]  = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C0000};
        // single write: consumer 0 stores 0xA5 at 0x03
        tbl[7]  = '{4'b0000, 4'b0001, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 16'h0003, 16'h00A5, 4'b0000, 4'b0000, 32'h005C0000};
        tbl[8]  = '{4'b0000, 4'b0001, 2'b00, 2'b01, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0001, 32'h005C0000};
        tbl[9]  = '{4'b0000, 4'b0001, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0001, 32'h005C0000};
        tbl[10] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C0000};
        // consumer 1 read+write: read first, write claimed in the first idle cycle after release
        tbl[11] = '{4'b0010, 4'b0010, 2'b00, 2'b00, 16'h0000, 2'b01, 16'h0021, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C0000};
        tbl[12] = '{4'b0010, 4'b0010, 2'b01, 2'b00, 16'h0077, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 32'h005C7700};
        tbl[13] = '{4'b0000, 4'b0010, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C7700};
        tbl[14] = '{4'b0000, 4'b0010, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 16'h0044, 16'h00B6, 4'b0000, 4'b0000, 32'h005C7700};
        tbl[15] = '{4'b0000, 4'b0010, 2'b00, 2'b01, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 32'h005C7700};
        tbl[16] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C7700};
        // contention: consumers 0,1,3; consumer 3 waits for channel 1 to free up
        tbl[17] = '{4'b1011, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b11, 16'h2110, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005C7700};
        tbl[18] = '{4'b1011, 4'b0000, 2'b10, 2'b00, 16'hE100, 2'b01, 16'h0010, 2'b00, 16'h0000, 16'h0000, 4'b0010, 4'b0000, 32'h005CE100};
        tbl[19] = '{4'b1001, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b01, 16'h0010, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005CE100};
        tbl[20] = '{4'b1001, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b11, 16'h3F10, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'h005CE100};
        tbl[21] = '{4'b1001, 4'b0000, 2'b11, 2'b00, 16'hF30F, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1001, 4'b0000, 32'hF35CE10F};
        tbl[22] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'hF35CE10F};
        tbl[23] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'hF35CE10F};
        // early drop: consumer 2 write, valid released while waiting
        tbl[24] = '{4'b0000, 4'b0100, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 16'h0055, 16'h00C7, 4'b0000, 4'b0000, 32'hF35CE10F};
        tbl[25] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b01, 16'h0055, 16'h00C7, 4'b0000, 4'b0000, 32'hF35CE10F};
        tbl[26] = '{4'b0000, 4'b0000, 2'b00, 2'b01, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0100, 32'hF35CE10F};
        tbl[27] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'hF35CE10F};
        tbl[28] = '{4'b0000, 4'b0000, 2'b00, 2'b00, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 32'hF35CE10F};

        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_read_valid", -1, 32'(mrv), 32'h0);
        chk("reset mem_write_valid", -1, 32'(mwv), 32'h0);
        chk("reset consumer_read_ready", -1, 32'(crr), 32'h0);
        chk("reset consumer_write_ready", -1, 32'(cwr), 32'h0);
        chk("reset consumer_read_data", -1, crd, 32'h0);
        chk("reset mem addresses", -1, {mra, mwa}, 32'h0);
        reset = 1'b1;

        for (int k = 0; k < NROWS; k++) run_row(k);

        // Reset asserted mid-read, then a fresh read completes normally.
        rv = 4'b0001;
        @(posedge clk);
        #1;
        chk("pre-reset mem_read_valid", 100, 32'(mrv), 32'h1);
        chk("pre-reset mem_read_address", 100, 32'(mra[0]), 32'h10);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset mem_read_valid", 101, 32'(mrv), 32'h0);
        chk("async reset mem_read_address", 101, 32'(mra), 32'h0);
        chk("async reset ready", 101, {28'h0, crr}, 32'h0);
        chk("async reset read_data", 101, crd, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset mem_read_valid", 102, 32'(mrv), 32'h1);
        chk("post-reset mem_read_address", 102, 32'(mra[0]), 32'h10);
        mrr = 2'b01;
        mrd = 16'h0099;
        @(posedge clk);
        #1;
        chk("post-reset read_ready", 103, 32'(crr), 32'h1);
        chk("post-reset read_data", 103, crd, 32'h00000099);
        chk("post-reset mem_read_valid drop", 103, 32'(mrv), 32'h0);
        mrr = 2'b00;
        rv  = 4'b0000;
        @(posedge clk);
        #1;
        chk("post-reset ready release", 104, 32'(crr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, 8, address width; DATA_BITS, 8, data width; NUM_CONSUMERS, 4, LSUs served; NUM_CHANNELS, 2, concurrent memory channels.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports `clk` and `reset` SHALL use the codebase names.
REQ-003 Ports: clk  in  1  clock.
REQ-004 Ports: reset  in  1  async active-low reset.
REQ-005 Ports: consumer_read_valid  in  [NUM_CONSUMERS]  LSU load request.
REQ-006 Ports: consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  load address.
REQ-007 Ports: consumer_read_ready  out  [NUM_CONSUMERS]  load complete, data valid.
REQ-008 Ports: consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  load data.
REQ-009 Ports: consumer_write_valid, consumer_write_address, consumer_write_data  in  per consumer  store request.
REQ-010 Ports: consumer_write_ready  out  [NUM_CONSUMERS]  store complete.
REQ-011 Ports: mem_read_valid, mem_read_address  out  per channel; mem_read_ready, mem_read_data  in  per channel.
REQ-012 Ports: mem_write_valid, mem_write_address, mem_write_data  out  per channel; mem_write_ready  in  per channel.

Function
REQ-013 Each channel SHALL run a registered FSM with states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING and WRITE_RELAYING.
REQ-014 In IDLE, a channel SHALL claim the lowest-index consumer that is requesting and not already claimed.
  - Read SHALL win over write when the claimed consumer asserts both.
REQ-015 Within one cycle, channels SHALL claim in ascending channel index; no consumer SHALL be claimed by two channels.
REQ-016 On a read claim, the next cycle SHALL have mem_read_valid=1 and mem_read_address=consumer address; state SHALL go to READ_WAITING.
REQ-017 On a write claim, the next cycle SHALL have mem_write_valid, mem_write_address and mem_write_data set; state SHALL go to WRITE_WAITING.
REQ-018 READ_WAITING, on mem_read_ready=1, SHALL:
  - deassert mem_read_valid;
  - register mem_read_data into consumer_read_data;
  - assert consumer_read_ready;
  - go to READ_RELAYING.
REQ-019 WRITE_WAITING, on mem_write_ready=1, SHALL deassert mem_write_valid, assert consumer_write_ready and go to WRITE_RELAYING.
REQ-020 In a RELAYING state, ready SHALL stay high while the consumer valid stays high.
  - When the consumer valid is seen low, ready SHALL clear, the claim SHALL release and the state SHALL go to IDLE.
  - The released consumer SHALL be claimable in that same next IDLE cycle.
REQ-021 Latency: consumer valid at cycle N -> mem valid at N+1; mem ready at M -> consumer ready at M+1; no combinational path SHALL run from any input to any output.
REQ-022 consumer_read_data SHALL hold its last value until the next read completes for that consumer.
REQ-023 A consumer dropping valid during WAITING SHALL NOT abort the transaction; completion and relay SHALL still occur, then the claim SHALL release.
REQ-024 With more requesters than channels, unclaimed consumers SHALL wait with no output change; starvation under fixed priority is accepted.

Reset
REQ-025 Asserting reset at any time, including mid-transaction, SHALL immediately force:
  - all channel states to IDLE and all claims cleared;
  - all mem_*_valid, consumer_*_ready, addresses and data to 0.
REQ-026 After reset deasserts, the first claim SHALL occur on the first clk edge at which a request is present.

Structure
REQ-027 The channel state enum SHALL live in shared package states_pkg, alongside the existing LSU and core state types.
REQ-028 The block SHALL be a single module with no sub-modules; channel logic SHALL use a generate/for loop with an explicit claimed-consumer mask.

Verification
REQ-029 Single read: consumer 2 reads addr 0x1A, memory returns 0x5C after 3 cycles.
  -> mem_read_valid one cycle after the request;
  -> consumer_read_data[2]=0x5C with ready one cycle after mem ready;
  -> ready drops after valid drops.
REQ-030 Single write: consumer 0 writes 0xA5 to 0x03.
  -> mem_write_address=0x03, mem_write_data=0xA5;
  -> consumer_write_ready[0] pulses until valid drops.
REQ-031 Contention: consumers 0, 1 and 3 request in the same cycle with 2 channels.
  -> channel 0 takes 0, channel 1 takes 1;
  -> 3 is served only after a channel returns to IDLE.
REQ-032 Reset mid-read: reset asserted while in READ_WAITING.
  -> all valid/ready outputs 0 immediately;
  -> new request after reset completes normally.
REQ-033 Both directions: consumer 1 asserts read and write simultaneously.
  -> read is served first; write is served after the read relay completes.
REQ-034 Early drop: consumer valid dropped in WAITING.
  -> ready still asserted for one cycle, then the channel returns to IDLE.
